axa_error_monitor: RTL and testbench

- Hardware response-side checker for the approximate-adder family (AXA1..AXA3 and wider ripple variants).
- Consumes a handshaked stream of operands together with the result produced by the approximate adder under test.
- Computes the exact sum, the per-sample error distance (ED) and window statistics: sample count, error count, summed ED and maximum ED.
- Sits between the adder under test and readout logic; it is the receiving end of the operand/result stream that a stimulus driver produces.

---
 rtl/axa_mon_pkg.sv | 26 ++
 rtl/axa_ed_stage.sv | 49 ++++
 rtl/axa_error_monitor.sv | 138 +++++++++++++
 tb/tb_axa_error_monitor.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/axa_mon_pkg.sv
// Shared types and helpers for the approximate-adder error monitor.
package axa_mon_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Error distance needs one bit more than the operands to hold a full carry mismatch.
  function automatic int ed_w(input int width);
    return width + 1;
  endfunction

  function automatic logic [63:0] sat_add(input logic [63:0] acc,
                                          input logic [63:0] inc,
                                          input int          acc_w);
    logic [63:0] lim;
    logic [63:0] s;
    lim = (acc_w >= 64) ? '1 : ((64'd1 << acc_w) - 64'd1);
    s   = acc + inc;
    return ((s > lim) || (s < acc)) ? lim : s;
  endfunction

endpackage

// File: rtl/axa_ed_stage.sv
// Stage 1: exact sum, signed difference against the approximate result, |ED| register.
// One cycle latency; flush_i drops any beat in flight.
module axa_ed_stage #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             accept_i,
  input  logic [WIDTH-1:0] op_a_i,
  input  logic [WIDTH-1:0] op_b_i,
  input  logic             cin_i,
  input  logic [WIDTH-1:0] apx_sum_i,
  input  logic             apx_cout_i,
  output logic             s1_vld_o,
  output logic [WIDTH:0]   s1_ed_o
);
  import axa_mon_pkg::*;

  localparam int ED_W = ed_w(WIDTH);

  logic [WIDTH:0]          exact;
  logic [WIDTH:0]          approx;
  logic signed [WIDTH+1:0] diff;
  logic [WIDTH:0]          ed_d;
  logic                    s1_vld_q;
  logic [WIDTH:0]          s1_ed_q;

  always_comb begin
    exact  = {1'b0, op_a_i} + {1'b0, op_b_i} + {{WIDTH{1'b0}}, cin_i};
    approx = {apx_cout_i, apx_sum_i};
    diff   = $signed({1'b0, approx}) - $signed({1'b0, exact});
    ed_d   = diff[WIDTH+1] ? ED_W'(-diff) : ED_W'(diff);
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush_i) begin
      s1_vld_q <= 1'b0;
      s1_ed_q  <= '0;
    end else begin
      s1_vld_q <= accept_i;
      if (accept_i) s1_ed_q <= ed_d;
    end
  end

  assign s1_vld_o = s1_vld_q;
  assign s1_ed_o  = s1_ed_q;

endmodule

// File: rtl/axa_error_monitor.sv
// Window-based error statistics for an approximate adder's operand/result stream.
// Beat accepted at cycle t shows in the stats at t+2; in_ready is high only in RUN.
module axa_error_monitor #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16,
  parameter int ACC_W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             clear,
  input  logic [CNT_W-1:0] num_samples,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  input  logic [WIDTH-1:0] apx_sum,
  input  logic             apx_cout,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [ACC_W-1:0] sum_ed,
  output logic [WIDTH:0]   max_ed
);
  import axa_mon_pkg::*;

  localparam int ED_W = ed_w(WIDTH);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] n_q, n_d;
  logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d;
  logic [CNT_W-1:0] sample_q, sample_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic [ACC_W-1:0] sum_q, sum_d;
  logic [ED_W-1:0]  max_q, max_d;
  logic             stats_clr;
  logic             accept;
  logic             s1_vld;
  logic [ED_W-1:0]  s1_ed;

  assign in_ready = (state_q == RUN);
  assign accept   = in_valid & in_ready;

  axa_ed_stage #(.WIDTH(WIDTH)) u_ed_stage (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush_i    (clear),
    .accept_i   (accept),
    .op_a_i     (op_a),
    .op_b_i     (op_b),
    .cin_i      (cin),
    .apx_sum_i  (apx_sum),
    .apx_cout_i (apx_cout),
    .s1_vld_o   (s1_vld),
    .s1_ed_o    (s1_ed)
  );

  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    acc_cnt_d = acc_cnt_q;
    stats_clr = 1'b0;
    if (clear) begin
      state_d   = IDLE;
      stats_clr = 1'b1;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            stats_clr = 1'b1;
            n_d       = num_samples;
            acc_cnt_d = '0;
            state_d   = (num_samples == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (accept) begin
            acc_cnt_d = CNT_W'(acc_cnt_q + 1'b1);
            if (CNT_W'(acc_cnt_q + 1'b1) == n_q) state_d = DRAIN;
          end
        end
        // The last beat sits in stage 1 for one DRAIN cycle and lands in the stats on the next.
        DRAIN: begin
          if (!s1_vld) state_d = DONE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    sample_d = sample_q;
    err_d    = err_q;
    sum_d    = sum_q;
    max_d    = max_q;
    if (stats_clr) begin
      sample_d = '0;
      err_d    = '0;
      sum_d    = '0;
      max_d    = '0;
    end else if (s1_vld) begin
      sample_d = CNT_W'(sample_q + 1'b1);
      err_d    = CNT_W'(err_q + CNT_W'(s1_ed != '0));
      sum_d    = ACC_W'(sat_add(64'(sum_q), 64'(s1_ed), ACC_W));
      max_d    = (s1_ed > max_q) ? s1_ed : max_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      n_q       <= '0;
      acc_cnt_q <= '0;
      sample_q  <= '0;
      err_q     <= '0;
      sum_q     <= '0;
      max_q     <= '0;
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      acc_cnt_q <= acc_cnt_d;
      sample_q  <= sample_d;
      err_q     <= err_d;
      sum_q     <= sum_d;
      max_q     <= max_d;
    end
  end

  assign busy       = (state_q == RUN) || (state_q == DRAIN);
  assign done       = (state_q == DONE);
  assign sample_cnt = sample_q;
  assign err_cnt    = err_q;
  assign sum_ed     = sum_q;
  assign max_ed     = max_q;

endmodule

// File: tb/tb_axa_error_monitor.sv
// Randomized windows against a list-based reference; a second instance with a 2-bit accumulator covers saturation.
module tb_axa_error_monitor;
  localparam int W   = 1;
  localparam int CW  = 16;
  localparam int AW  = 24;
  localparam int AWS = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          clear = 1'b0;
  logic [CW-1:0] num_samples = '0;
  logic          in_valid = 1'b0;
  logic [W-1:0]  op_a = '0, op_b = '0, apx_sum = '0;
  logic          cin = 1'b0, apx_cout = 1'b0;

  logic          in_ready, busy, done;
  logic [CW-1:0] sample_cnt, err_cnt;
  logic [AW-1:0] sum_ed;
  logic [W:0]    max_ed;
  logic          s_in_ready, s_busy, s_done;
  logic [CW-1:0] s_sample_cnt, s_err_cnt;
  logic [AWS-1:0] s_sum_ed;
  logic [W:0]    s_max_ed;

  always #5 clk = ~clk;

  axa_error_monitor #(.WIDTH(W), .CNT_W(CW), .ACC_W(AW)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .clear(clear), .num_samples(num_samples),
    .in_valid(in_valid), .in_ready(in_ready), .op_a(op_a), .op_b(op_b), .cin(cin),
    .apx_sum(apx_sum), .apx_cout(apx_cout), .busy(busy), .done(done),
    .sample_cnt(sample_cnt), .err_cnt(err_cnt), .sum_ed(sum_ed), .max_ed(max_ed));

  axa_error_monitor #(.WIDTH(W), .CNT_W(CW), .ACC_W(AWS)) u_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .clear(clear), .num_samples(num_samples),
    .in_valid(in_valid), .in_ready(s_in_ready), .op_a(op_a), .op_b(op_b), .cin(cin),
    .apx_sum(apx_sum), .apx_cout(apx_cout), .busy(s_busy), .done(s_done),
    .sample_cnt(s_sample_cnt), .err_cnt(s_err_cnt), .sum_ed(s_sum_ed), .max_ed(s_max_ed));

  typedef struct { int a; int b; int c; int s; int co; } beat_t;
  typedef struct { int cnt; int err; int sum; int mx; } exp_t;

  beat_t beats[$];
  exp_t  sb[$];
  int    total = 0;
  int    bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int ed_of(input beat_t bt);
    int ex;
    int ap;
    ex = bt.a + bt.b + bt.c;
    ap = bt.co * (2 ** W) + bt.s;
    return (ex > ap) ? ex - ap : ap - ex;
  endfunction

  function automatic beat_t mk(input int a, input int b, input int c, input int co, input int s);
    beat_t bt;
    bt.a = a; bt.b = b; bt.c = c; bt.co = co; bt.s = s;
    return bt;
  endfunction

  function automatic beat_t rnd_beat();
    beat_t bt;
    int    sum;
    bt.a = $urandom_range(0, 2 ** W - 1);
    bt.b = $urandom_range(0, 2 ** W - 1);
    bt.c = $urandom_range(0, 1);
    if ($urandom_range(0, 1) == 1) begin
      sum   = bt.a + bt.b + bt.c;
      bt.s  = sum % (2 ** W);
      bt.co = sum / (2 ** W);
    end else begin
      bt.s  = $urandom_range(0, 2 ** W - 1);
      bt.co = $urandom_range(0, 1);
    end
    return bt;
  endfunction

  task automatic drive_beat(input beat_t bt);
    op_a     = bt.a[W-1:0];
    op_b     = bt.b[W-1:0];
    cin      = bt.c[0];
    apx_sum  = bt.s[W-1:0];
    apx_cout = bt.co[0];
  endtask

  task automatic all_zero(input string tag);
    chk({tag, "_ready"}, in_ready, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_cnt"}, sample_cnt, 0);
    chk({tag, "_err"}, err_cnt, 0);
    chk({tag, "_sum"}, sum_ed, 0);
    chk({tag, "_max"}, max_ed, 0);
    chk({tag, "_sat_sum"}, s_sum_ed, 0);
  endtask

  // Monitor: each fresh entry into DONE consumes one expected window.
  logic done_prev = 1'b0;
  logic start_taken = 1'b0;
  always @(posedge clk) start_taken = start & ~clear & rst_n;
  always @(negedge clk) begin
    exp_t e;
    chk("busy_done_excl", busy & done, 0);
    if (done && (!done_prev || start_taken)) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done=1 expected no window pending");
      end else begin
        e = sb.pop_front();
        chk("sample_cnt", sample_cnt, e.cnt);
        chk("err_cnt", err_cnt, e.err);
        chk("sum_ed", sum_ed, e.sum);
        chk("max_ed", max_ed, e.mx);
        chk("sat_err_cnt", s_err_cnt, e.err);
        chk("sat_sum_ed", s_sum_ed, (e.sum > (2 ** AWS - 1)) ? (2 ** AWS - 1) : e.sum);
        chk("sat_max_ed", s_max_ed, e.mx);
      end
    end
    done_prev = done;
  end

  // One measurement window; abort_after/rst_after >= 0 cut it short after that many accepts.
  task automatic window(input int n, input int gap, input int abort_after,
                        input int rst_after, input int start_in_run);
    exp_t e;
    int   acc, last_acc, seen, ed;
    int   hist[$];
    bit   finished;
    while (beats.size() < n) beats.push_back(rnd_beat());
    e = '{0, 0, 0, 0};
    for (int i = 0; i < n; i++) begin
      ed = ed_of(beats[i]);
      e.cnt++;
      if (ed != 0) e.err++;
      e.sum += ed;
      if (ed > e.mx) e.mx = ed;
    end
    if (abort_after < 0 && rst_after < 0) sb.push_back(e);

    @(negedge clk);
    in_valid = 1'b0;
    start = 1'b1;
    num_samples = CW'(n);
    @(negedge clk);
    start = 1'b0;
    num_samples = CW'($urandom_range(0, 200));
    if (n == 0) begin
      chk("n0_done", done, 1);
      chk("n0_busy", busy, 0);
      chk("n0_cnt", sample_cnt, 0);
      chk("n0_sum", sum_ed, 0);
      beats.delete();
      return;
    end
    chk("run_busy", busy, 1);

    acc = 0;
    last_acc = -10;
    finished = 0;
    for (int cyc = 0; cyc < 4 * n + 12; cyc++) begin
      seen = 0;
      foreach (hist[i]) if (hist[i] <= cyc - 2) seen++;
      chk("latency_cnt", sample_cnt, seen);
      if (acc == n && cyc > last_acc) begin
        if (cyc <= last_acc + 2) begin
          chk("drain_ready", in_ready, 0);
          chk("drain_busy", busy, 1);
        end else begin
          chk("done_after_drain", done, 1);
          finished = 1;
          break;
        end
      end
      if (abort_after >= 0 && acc == abort_after) begin
        in_valid = 1'b0;
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        all_zero("clear");
        finished = 1;
        break;
      end
      if (rst_after >= 0 && acc == rst_after) begin
        in_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        all_zero("midreset");
        finished = 1;
        break;
      end
      start = (start_in_run != 0 && cyc == 1);
      if (start) num_samples = CW'(1);
      in_valid = !(gap != 0 && (cyc % 2) == 1);
      drive_beat((acc < n) ? beats[acc] : rnd_beat());
      if (in_valid && in_ready && acc < n) begin
        hist.push_back(cyc);
        acc++;
        last_acc = cyc;
      end
      @(negedge clk);
    end
    if (!finished) begin
      total++;
      bad++;
      $display("FAIL window_timeout: got %0d accepts expected %0d", acc, n);
    end
    in_valid = 1'b0;
    start = 1'b0;
    beats.delete();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    all_zero("reset");
    rst_n = 1'b1;

    // Exact beats
    beats.push_back(mk(0, 0, 0, 0, 0));
    beats.push_back(mk(0, 0, 1, 0, 1));
    beats.push_back(mk(0, 1, 1, 1, 0));
    beats.push_back(mk(1, 1, 0, 1, 0));
    window(4, 0, -1, -1, 0);
    // Errors
    beats.push_back(mk(0, 0, 1, 0, 0));
    beats.push_back(mk(1, 1, 1, 0, 1));
    beats.push_back(mk(0, 1, 0, 0, 1));
    window(3, 0, -1, -1, 0);
    // Backpressure: valid held through drain
    window(4, 0, -1, -1, 0);
    // Gaps, then abort after 3 accepts
    window(5, 1, -1, -1, 0);
    window(5, 1, 3, -1, 0);
    // Edge cases
    window(0, 0, -1, -1, 0);
    window(4, 0, -1, -1, 1);
    window(5, 0, -1, 2, 0);
    window(0, 0, -1, -1, 0);
    // Saturation on the 2-bit accumulator
    for (int i = 0; i < 3; i++) beats.push_back(mk(1, 1, 1, 0, 1));
    window(3, 0, -1, -1, 0);

    for (int k = 0; k < 24; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("rnd_clear_done", done, 0);
      end
      window($urandom_range(1, 8), $urandom_range(0, 1), -1, -1, $urandom_range(0, 1));
    end

    repeat (4) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
